// File: rtl/led_pulse_stretcher.sv
// Turns short event pulses into visible LED blinks with a mandatory dark gap.
// Events that arrive during a blink or gap are queued and replayed in order.
module led_pulse_stretcher #(
  parameter int DIV       = 1000000,
  parameter int ON_TICKS  = 10,
  parameter int OFF_TICKS = 5,
  parameter int PEND_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              clr_ovf,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  // state | meaning: IDLE dark, waiting | ON blink lit | GAP dark separator
  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t            state_q, state_d;
  logic              prev_q, prev_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;

  logic ev, presc_last, on_done, gap_done;
  logic enter, inc, dec, ovf_set;

  always_comb begin
    ev         = pulse_in & ~prev_q;
    prev_d     = pulse_in;
    presc_last = (presc_q == PW'(DIV - 1));
    on_done    = presc_last && (tick_q == TW'(ON_TICKS - 1));
    gap_done   = presc_last && (tick_q == TW'(OFF_TICKS - 1));

    state_d = state_q;
    enter   = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;
    ovf_set = 1'b0;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    presc_d = presc_q;
    tick_d  = tick_q;

    case (state_q)
      IDLE: begin
        if (ev) begin
          state_d = ON;
          enter   = 1'b1;
        end
      end
      ON: begin
        inc = ev;
        if (on_done) begin
          state_d = GAP;
          enter   = 1'b1;
        end
      end
      GAP: begin
        if (gap_done) begin
          enter = 1'b1;
          if (pend_q != '0) begin
            // replay a queued event; a coincident new event re-queues it
            state_d = ON;
            dec     = 1'b1;
            inc     = ev;
          end else if (ev) begin
            state_d = ON;
          end else begin
            state_d = IDLE;
          end
        end else begin
          inc = ev;
        end
      end
      default: begin
        state_d = IDLE;
        enter   = 1'b1;
      end
    endcase

    if (inc && !dec) begin
      if (&pend_q) ovf_set = 1'b1;
      else         pend_d  = pend_q + PEND_W'(1);
    end else if (dec && !inc) begin
      pend_d = pend_q - PEND_W'(1);
    end

    if (clr_ovf) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;

    if (enter) begin
      presc_d = '0;
      tick_d  = '0;
    end else if (state_q != IDLE) begin
      if (presc_last) begin
        presc_d = '0;
        tick_d  = tick_q + TW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= 1'b0;
      presc_q <= '0;
      tick_q  <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign led_out  = (state_q == ON);
  assign busy     = (state_q != IDLE);
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher with DIV=2, ON_TICKS=3, OFF_TICKS=2,
// PEND_W=2: a blink is 6 cycles and a gap is 4 cycles.
module tb_led_pulse_stretcher;

  localparam int DIV   = 2;
  localparam int ON_T  = 3;
  localparam int OFF_T = 2;
  localparam int PW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pulse_in = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  led_pulse_stretcher #(
    .DIV(DIV), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .PEND_W(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clr_ovf(clr_ovf),
    .led_out(led_out), .busy(busy), .pending(pending), .overflow(overflow)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (led_out !== 1'b0) $display("FAIL reset_led led_out=%0b expected 0", led_out);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy busy=%0b expected 0", busy);
    else n_pass++;
    n_checks++;
    if (pending !== 2'd0) $display("FAIL reset_pending pending=%0d expected 0", pending);
    else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow overflow=%0b expected 0", overflow);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle busy=%0b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_single_blink;
    logic e_led, e_busy;
    pulse_in = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      pulse_in = 1'b0;
      e_led  = (i < 6);
      e_busy = (i < 10);
      n_checks++;
      if (led_out !== e_led) $display("FAIL single_led i=%0d led_out=%0b expected %0b", i, led_out, e_led);
      else n_pass++;
      n_checks++;
      if (busy !== e_busy) $display("FAIL single_busy i=%0d busy=%0b expected %0b", i, busy, e_busy);
      else n_pass++;
      n_checks++;
      if (pending !== 2'd0) $display("FAIL single_pending i=%0d pending=%0d expected 0", i, pending);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_long_input;
    logic e_led, e_busy;
    pulse_in = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      pulse_in = (i < 19);
      e_led  = (i < 6);
      e_busy = (i < 10);
      n_checks++;
      if (led_out !== e_led) $display("FAIL long_led i=%0d led_out=%0b expected %0b", i, led_out, e_led);
      else n_pass++;
      n_checks++;
      if (busy !== e_busy) $display("FAIL long_busy i=%0d busy=%0b expected %0b", i, busy, e_busy);
      else n_pass++;
      n_checks++;
      if (pending !== 2'd0) $display("FAIL long_pending i=%0d pending=%0d expected 0", i, pending);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_queueing;
    logic e_led, e_busy;
    logic [PW-1:0] e_pend;
    pulse_in = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 43; i++) begin
      pulse_in = (i == 1 || i == 3 || i == 5);
      e_led  = (i < 40) && ((i % 10) < 6);
      e_busy = (i < 40);
      if (i < 2)       e_pend = 2'd0;
      else if (i < 4)  e_pend = 2'd1;
      else if (i < 6)  e_pend = 2'd2;
      else if (i < 10) e_pend = 2'd3;
      else if (i < 20) e_pend = 2'd2;
      else if (i < 30) e_pend = 2'd1;
      else             e_pend = 2'd0;
      n_checks++;
      if (led_out !== e_led) $display("FAIL queue_led i=%0d led_out=%0b expected %0b", i, led_out, e_led);
      else n_pass++;
      n_checks++;
      if (busy !== e_busy) $display("FAIL queue_busy i=%0d busy=%0b expected %0b", i, busy, e_busy);
      else n_pass++;
      n_checks++;
      if (pending !== e_pend) $display("FAIL queue_pending i=%0d pending=%0d expected %0d", i, pending, e_pend);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_gap_exit_empty;
    logic e_led, e_busy;
    pulse_in = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 23; i++) begin
      pulse_in = (i == 9);
      e_led  = (i < 6) || (i >= 10 && i < 16);
      e_busy = (i < 20);
      n_checks++;
      if (led_out !== e_led) $display("FAIL gapA_led i=%0d led_out=%0b expected %0b", i, led_out, e_led);
      else n_pass++;
      n_checks++;
      if (busy !== e_busy) $display("FAIL gapA_busy i=%0d busy=%0b expected %0b", i, busy, e_busy);
      else n_pass++;
      n_checks++;
      if (pending !== 2'd0) $display("FAIL gapA_pending i=%0d pending=%0d expected 0", i, pending);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_gap_exit_pending;
    logic e_led, e_busy;
    logic [PW-1:0] e_pend;
    pulse_in = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 43; i++) begin
      pulse_in = (i == 1 || i == 3 || i == 9);
      e_led  = (i < 40) && ((i % 10) < 6);
      e_busy = (i < 40);
      if (i < 2)       e_pend = 2'd0;
      else if (i < 4)  e_pend = 2'd1;
      else if (i < 20) e_pend = 2'd2;
      else if (i < 30) e_pend = 2'd1;
      else             e_pend = 2'd0;
      n_checks++;
      if (led_out !== e_led) $display("FAIL gapB_led i=%0d led_out=%0b expected %0b", i, led_out, e_led);
      else n_pass++;
      n_checks++;
      if (busy !== e_busy) $display("FAIL gapB_busy i=%0d busy=%0b expected %0b", i, busy, e_busy);
      else n_pass++;
      n_checks++;
      if (pending !== e_pend) $display("FAIL gapB_pending i=%0d pending=%0d expected %0d", i, pending, e_pend);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_saturation;
    logic e_led, e_busy, e_ovf;
    logic [PW-1:0] e_pend;
    pulse_in = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 53; i++) begin
      pulse_in = (i == 1 || i == 3 || i == 5 || i == 7 || i == 11 || i == 13);
      clr_ovf  = (i == 13 || i == 14);
      e_led  = (i < 50) && ((i % 10) < 6);
      e_busy = (i < 50);
      e_ovf  = (i >= 8 && i <= 14);
      if (i < 2)       e_pend = 2'd0;
      else if (i < 4)  e_pend = 2'd1;
      else if (i < 6)  e_pend = 2'd2;
      else if (i < 10) e_pend = 2'd3;
      else if (i < 12) e_pend = 2'd2;
      else if (i < 20) e_pend = 2'd3;
      else if (i < 30) e_pend = 2'd2;
      else if (i < 40) e_pend = 2'd1;
      else             e_pend = 2'd0;
      n_checks++;
      if (led_out !== e_led) $display("FAIL sat_led i=%0d led_out=%0b expected %0b", i, led_out, e_led);
      else n_pass++;
      n_checks++;
      if (busy !== e_busy) $display("FAIL sat_busy i=%0d busy=%0b expected %0b", i, busy, e_busy);
      else n_pass++;
      n_checks++;
      if (pending !== e_pend) $display("FAIL sat_pending i=%0d pending=%0d expected %0d", i, pending, e_pend);
      else n_pass++;
      n_checks++;
      if (overflow !== e_ovf) $display("FAIL sat_overflow i=%0d overflow=%0b expected %0b", i, overflow, e_ovf);
      else n_pass++;
      @(negedge clk);
    end
    clr_ovf = 1'b0;
  endtask

  task automatic test_reset_mid_blink;
    logic e_led, e_busy;
    pulse_in = 1'b1;
    @(negedge clk);
    pulse_in = 1'b0;
    @(negedge clk);
    pulse_in = 1'b1;
    @(negedge clk);
    pulse_in = 1'b0;
    n_checks++;
    if (pending !== 2'd1) $display("FAIL midrst_pre_pending pending=%0d expected 1", pending);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (led_out !== 1'b1) $display("FAIL midrst_pre_led led_out=%0b expected 1", led_out);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (led_out !== 1'b0) $display("FAIL midrst_led led_out=%0b expected 0", led_out);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL midrst_busy busy=%0b expected 0", busy);
    else n_pass++;
    n_checks++;
    if (pending !== 2'd0) $display("FAIL midrst_pending pending=%0d expected 0", pending);
    else n_pass++;
    pulse_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      e_led  = (i < 6);
      e_busy = (i < 10);
      n_checks++;
      if (led_out !== e_led) $display("FAIL release_led i=%0d led_out=%0b expected %0b", i, led_out, e_led);
      else n_pass++;
      n_checks++;
      if (busy !== e_busy) $display("FAIL release_busy i=%0d busy=%0b expected %0b", i, busy, e_busy);
      else n_pass++;
      @(negedge clk);
    end
    pulse_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_blink();
    test_long_input();
    test_queueing();
    test_gap_exit_empty();
    test_gap_exit_pending();
    test_saturation();
    test_reset_mid_blink();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
